sim_chan_incr: RTL and testbench
================================

# sim_chan_incr

Parametrised multi-channel increment engine for the simulation top level. It replaces the fixed small/quad/wide combinational incrementers with NCH independent valid/ready channels of configurable width. Each channel has a DEPTH-entry output FIFO. A run-control FSM (idle/run/drain/done) with a cycle counter lets the C++ harness start a run, stop it, and wait for all results to drain.

## Interface
- NCH, 3, number of independent channels (1..8)
- WIDTH, 70, data width per channel (1..128)
- INC, 1, constant added to each accepted word, truncated to WIDTH bits
- DEPTH, 4, output FIFO entries per channel (power of 2, >=2)

Ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin a run (honoured in IDLE or DONE)
- stop  in  1  end input acceptance (honoured in RUN)
- in_valid  in  NCH  per-channel input valid
- in_ready  out  NCH  per-channel input ready
- in_data  in  NCH*WIDTH  channel c at bits [c*WIDTH +: WIDTH]
- out_valid  out  NCH  per-channel result valid
- out_ready  in  NCH  per-channel result ready
- out_data  out  NCH*WIDTH  packed as in_data
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- cycle_cnt  out  32  cycles spent in RUN+DRAIN for the current or last run

## Operation
- Clock and reset are fixed: one clock, asynchronous active-high reset. No other clocks.
- FSM states: IDLE (reset state), RUN, DRAIN, DONE.
  - IDLE or DONE, start=1 -> RUN. cycle_cnt is cleared to 0 on this transition.
  - RUN, stop=1 -> DRAIN. start is ignored in RUN and DRAIN.
  - DRAIN, all FIFOs empty -> DONE. A stop in RUN with empty FIFOs passes through DRAIN for exactly one cycle.
- start and stop in the same cycle: in IDLE/DONE, start wins and stop is ignored. In RUN, stop wins.
- in_ready[c] = (state==RUN) && !full[c]. It does not credit a same-cycle pop.
- An input is accepted when in_valid[c] && in_ready[c]. The value pushed is in_data_c + INC, modulo 2^WIDTH (wrap).
- out_valid[c] = !empty[c]. out_data_c = the FIFO head entry. A pop occurs when out_valid[c] && out_ready[c].
- A simultaneous push and pop on a non-empty, non-full FIFO keeps the occupancy unchanged.
- Pointers are log2(DEPTH)+1 bits wide. Full = MSBs differ and LSBs equal. Pointers wrap naturally.
- Outputs drain in DRAIN and in DONE. Residual data can only exist in DONE if the FSM left DRAIN empty, so none exists there. IDLE also pops.
- cycle_cnt increments every cycle the state is RUN or DRAIN, and saturates at 0xFFFF_FFFF.
- Channels are fully independent; back-pressure on one channel never stalls another.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0 (FIFO storage is reset), busy=0, done=0, cycle_cnt=0, FSM in IDLE.
- start sampled at edge N -> busy=1 and in_ready (non-full) high after edge N.
- Latency: a word accepted at edge N gives out_valid=1 with its result after edge N (1 cycle, registered).
- Throughput: 1 word per cycle per channel while out_ready=1.
- stop sampled at edge N -> in_ready=0 after edge N. The word handshaken at edge N itself is still accepted.
- The last pop at edge M empties all FIFOs -> DONE after edge M+1.
- reset asserted mid-run: all outputs go to reset values immediately (asynchronously). In-flight data is discarded.

## Configuration
- Macro: SIM_CHAN_INCR_SAT_EN.
- Defined: the increment saturates. If in_data_c + INC >= 2^WIDTH, the pushed value is all-ones.
- Undefined: the increment wraps modulo 2^WIDTH (default).
- No other behaviour differs between the two builds.

## Test plan
- Reset, then start pulse, then 1 word per channel: ch0=0, ch1=5, ch2=all-ones (WIDTH=70) -> out_data 1, 6, 0 one cycle later. With SIM_CHAN_INCR_SAT_EN: ch2 gives all-ones.
- Hold out_ready[1]=0 and push 5 words to ch1 (DEPTH=4) -> in_ready[1] drops after 4 accepts while ch0 and ch2 still flow. Release out_ready -> 4 results in order, then the 5th accepted.
- Simultaneous push/pop at occupancy 2 for 10 cycles -> occupancy stays 2 and the outputs are in order.
- start and stop in the same cycle from IDLE -> RUN. Then stop with empty FIFOs -> DRAIN for 1 cycle, then DONE. cycle_cnt = 2.
- Run 100 cycles then stop with 3 words queued; drain over 3 cycles -> done rises, cycle_cnt = 104. A new start clears cycle_cnt to 0.
- Assert reset while FIFOs hold data mid-DRAIN -> out_valid=0, busy=0, cycle_cnt=0 immediately. After release, the block is in IDLE.

Source files
------------

// File: rtl/sim_chan_incr.sv
// sim_chan_incr: NCH independent valid/ready increment channels, each feeding a
// DEPTH-entry output FIFO, under an idle/run/drain/done run-control FSM with a
// saturating RUN+DRAIN cycle counter.
// Build macro SIM_CHAN_INCR_SAT_EN: saturate the increment at all-ones instead
// of wrapping modulo 2^WIDTH (default is wrap).

module sim_chan_incr_lane #(
  parameter int unsigned WIDTH = 70,
  parameter int unsigned INC   = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             accept_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);
  localparam int unsigned      AW    = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] data;
  } push_t;

  push_t                       push;
  logic [AW:0]                 wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        full, pop;

  // One extra pointer bit separates full from empty when the indices match.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign in_ready  = accept_en && !full;
  assign out_valid = !empty;
  assign out_data  = mem[rd_ptr[AW-1:0]];
  assign pop       = out_valid && out_ready;

`ifdef SIM_CHAN_INCR_SAT_EN
  logic [WIDTH:0] sum;
`endif

  // Accepted word plus INC; a carry out of WIDTH bits either wraps or clamps.
  always_comb begin
    push     = '0;
    push.vld = in_valid && in_ready;
`ifdef SIM_CHAN_INCR_SAT_EN
    sum       = {1'b0, in_data} + {1'b0, INC_W};
    push.data = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
`else
    push.data = in_data + INC_W;
`endif
  end

  // FIFO storage and pointers; storage is cleared so out_data resets to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (push.vld) begin
        mem[wr_ptr[AW-1:0]] <= push.data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

module sim_chan_incr #(
  parameter int unsigned NCH   = 3,
  parameter int unsigned WIDTH = 70,
  parameter int unsigned INC   = 1,
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stop,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          cycle_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [NCH-1:0]              empty;
  logic [NCH-1:0][WIDTH-1:0]   din, dout;
  logic                        all_empty, run_start, counting;

  assign din       = in_data;
  assign out_data  = dout;
  assign all_empty = &empty;
  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign counting  = busy;
  assign run_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    sim_chan_incr_lane #(
      .WIDTH (WIDTH),
      .INC   (INC),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .accept_en (state_q == S_RUN),
      .in_valid  (in_valid[c]),
      .in_ready  (in_ready[c]),
      .in_data   (din[c]),
      .out_valid (out_valid[c]),
      .out_ready (out_ready[c]),
      .out_data  (dout[c]),
      .empty     (empty[c])
    );
  end

  // Run-control next state: start only from IDLE/DONE, stop only from RUN,
  // DRAIN leaves once every FIFO is already empty (same-cycle pops not credited).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start)     state_d = S_RUN;
      S_RUN:          if (stop)      state_d = S_DRAIN;
      S_DRAIN:        if (all_empty) state_d = S_DONE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Cycle counter: cleared when a run starts, counts RUN+DRAIN, sticks at max.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               cycle_cnt <= '0;
    else if (run_start)                      cycle_cnt <= '0;
    else if (counting && (cycle_cnt != '1))  cycle_cnt <= cycle_cnt + 32'd1;
  end
endmodule

// File: tb/tb_sim_chan_incr.sv
// Self-checking bench for sim_chan_incr: queue-based reference model checked
// every cycle, a table of increment vectors, and hand-written corner sequences.
`timescale 1ns/1ps
module tb_sim_chan_incr;
  localparam int NCH = 3, W = 70, INC = 1, DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 reset, start, stop;
  logic [NCH-1:0]       in_valid, in_ready, out_valid, out_ready;
  logic [NCH*W-1:0]     in_data, out_data;
  logic                 busy, done;
  logic [31:0]          cycle_cnt;

  int n_chk = 0, n_fail = 0;

  // Reference model: run state (0 idle, 1 run, 2 drain, 3 done), one queue per channel.
  int         m_state;
  logic [W-1:0] mq [NCH][$];
  logic [31:0] m_cnt;

  typedef struct packed {
    logic [NCH-1:0][W-1:0] d;
    logic [NCH-1:0][W-1:0] e;
  } vec_t;
  vec_t tbl [4];

  always #5 clk = ~clk;

  sim_chan_incr #(.NCH(NCH), .WIDTH(W), .INC(INC), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done), .cycle_cnt(cycle_cnt)
  );

  function automatic logic [W-1:0] incr(input logic [W-1:0] d);
    logic [W-1:0] ones;
    ones = '1;
`ifdef SIM_CHAN_INCR_SAT_EN
    if (d > ones - W'(INC)) return ones;
`endif
    return d + W'(INC);
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_state = 0;
    m_cnt   = '0;
    for (int c = 0; c < NCH; c++) mq[c].delete();
  endtask

  task automatic check_model();
    logic [NCH-1:0] er, ev;
    for (int c = 0; c < NCH; c++) begin
      er[c] = (m_state == 1) && (mq[c].size() < DEPTH);
      ev[c] = (mq[c].size() != 0);
    end
    chk("in_ready", W'(in_ready), W'(er));
    chk("out_valid", W'(out_valid), W'(ev));
    for (int c = 0; c < NCH; c++)
      if (ev[c]) chk($sformatf("out_data%0d", c), out_data[c*W +: W], mq[c][0]);
    chk("busy", W'(busy), W'(m_state == 1 || m_state == 2));
    chk("done", W'(done), W'(m_state == 3));
    chk("cycle_cnt", W'(cycle_cnt), W'(m_cnt));
  endtask

  // Apply the inputs currently driven for one clock edge, advance the model, check.
  task automatic step();
    logic [NCH-1:0] pop, push;
    logic all_empty;
    all_empty = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (mq[c].size() != 0) all_empty = 1'b0;
      pop[c]  = (mq[c].size() != 0) && out_ready[c];
      push[c] = (m_state == 1) && (mq[c].size() < DEPTH) && in_valid[c];
    end
    case (m_state)
      0, 3: if (start) begin m_state = 1; m_cnt = '0; end
      1: begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (stop) m_state = 2;
      end
      default: begin
        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        if (all_empty) m_state = 3;
      end
    endcase
    for (int c = 0; c < NCH; c++) begin
      if (pop[c])  void'(mq[c].pop_front());
      if (push[c]) mq[c].push_back(incr(in_data[c*W +: W]));
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  function automatic logic [W-1:0] rnd_word();
    logic [W-1:0] v;
    v = {$urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) v = '1;
    return v;
  endfunction

  task automatic rnd_data();
    for (int c = 0; c < NCH; c++) in_data[c*W +: W] = rnd_word();
  endtask

  initial begin
    logic [W-1:0] ones;
    int k;
    ones = '1;

    tbl[0].d = {ones, W'(5), W'(0)};
`ifdef SIM_CHAN_INCR_SAT_EN
    tbl[0].e = {ones, W'(6), W'(1)};
`else
    tbl[0].e = {W'(0), W'(6), W'(1)};
`endif
    tbl[1].d = {70'h20_0000_0000_0000_0000, W'(41), ones - W'(1)};
    tbl[1].e = {70'h20_0000_0000_0000_0001, W'(42), ones};
    tbl[2].d = {70'h2A_FFFF_FFFF_FFFF_FFFF, W'(32'hFFFF_FFFF), W'(100)};
    tbl[2].e = {70'h2B_0000_0000_0000_0000, 70'h1_0000_0000, W'(101)};
    tbl[3].d = {W'(0), W'(7), ones};
`ifdef SIM_CHAN_INCR_SAT_EN
    tbl[3].e = {W'(1), W'(8), ones};
`else
    tbl[3].e = {W'(1), W'(8), W'(0)};
`endif

    reset = 1'b1; start = 1'b0; stop = 1'b0;
    in_valid = '0; out_ready = '0; in_data = '0;
    m_reset();
    repeat (2) @(negedge clk);
    chk("rst_in_ready", W'(in_ready), '0);
    chk("rst_out_valid", W'(out_valid), '0);
    for (int c = 0; c < NCH; c++) chk("rst_out_data", out_data[c*W +: W], '0);
    chk("rst_busy", W'(busy), '0);
    chk("rst_done", W'(done), '0);
    chk("rst_cycle_cnt", W'(cycle_cnt), '0);
    reset = 1'b0;
    @(negedge clk);

    // start+stop together from IDLE: start wins; then stop with empty FIFOs.
    start = 1'b1; stop = 1'b1; step();
    chk("ss_busy", W'(busy), W'(1));
    start = 1'b0; step();
    chk("drain_busy", W'(busy), W'(1));
    chk("drain_done", W'(done), W'(0));
    stop = 1'b0; step();
    chk("ss_done", W'(done), W'(1));
    chk("ss_cnt", W'(cycle_cnt), W'(2));
    start = 1'b1; step(); start = 1'b0;
    chk("restart_cnt", W'(cycle_cnt), W'(0));

    // Increment vectors, one word per channel per cycle, results one cycle later.
    out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      in_valid = '1;
      in_data  = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_valid", i), W'(out_valid), W'(3'b111));
      for (int c = 0; c < NCH; c++)
        chk($sformatf("tbl%0d_ch%0d", i, c), out_data[c*W +: W], tbl[i].e[c]);
    end
    in_valid = '0; step();

    // Back-pressure on ch1 only; ch0/ch2 keep flowing.
    out_ready = 3'b101; in_valid = '1;
    for (int i = 0; i < 4; i++) begin rnd_data(); step(); end
    chk("bp_ready", W'(in_ready), W'(3'b101));
    rnd_data(); step();
    chk("bp_hold_ready", W'(in_ready), W'(3'b101));
    in_valid = 3'b010; out_ready = '1; step();
    chk("bp_rel_ready", W'(in_ready[1]), W'(1));
    step();
    in_valid = '0;
    repeat (5) step();

    // Simultaneous push and pop at occupancy 2 on ch0.
    out_ready = '0; in_valid = 3'b001;
    repeat (2) begin rnd_data(); step(); end
    out_ready = 3'b001;
    repeat (10) begin rnd_data(); step(); end
    chk("occ_valid", W'(out_valid[0]), W'(1));
    in_valid = '0;
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    k = 0;
    while (!done && k < 20) begin step(); k++; end
    chk("stop_done", W'(done), W'(1));

    // 100-cycle run, 3 words queued at stop, drained over 3 cycles.
    out_ready = '0;
    start = 1'b1; step(); start = 1'b0;
    chk("run100_start_cnt", W'(cycle_cnt), W'(0));
    for (int i = 1; i <= 100; i++) begin
      in_valid = (i <= 3) ? 3'b001 : 3'b000;
      stop     = (i == 100);
      rnd_data();
      step();
    end
    stop = 1'b0; in_valid = '0; out_ready = '1;
    k = 0;
    while (!done && k < 20) begin step(); k++; end
    chk("run100_done", W'(done), W'(1));
    chk("run100_cnt", W'(cycle_cnt), W'(104));
    start = 1'b1; step(); start = 1'b0;
    chk("run100_restart_cnt", W'(cycle_cnt), W'(0));

    // Randomised traffic with occasional start/stop.
    for (int i = 0; i < 1500; i++) begin
      in_valid  = NCH'($urandom);
      out_ready = NCH'($urandom);
      start     = ($urandom_range(0, 30) == 0);
      stop      = ($urandom_range(0, 30) == 0);
      rnd_data();
      step();
    end
    start = 1'b0; stop = 1'b0; in_valid = '0;

    // Asynchronous reset while data is held in DRAIN.
    reset = 1'b1; m_reset();
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    out_ready = '0; in_valid = '1;
    repeat (3) begin rnd_data(); step(); end
    in_valid = '0;
    stop = 1'b1; step(); stop = 1'b0;
    chk("md_busy", W'(busy), W'(1));
    chk("md_valid", W'(out_valid), W'(3'b111));
    #2 reset = 1'b1;
    #1;
    chk("md_rst_out_valid", W'(out_valid), '0);
    chk("md_rst_busy", W'(busy), '0);
    chk("md_rst_cnt", W'(cycle_cnt), '0);
    chk("md_rst_in_ready", W'(in_ready), '0);
    for (int c = 0; c < NCH; c++) chk("md_rst_out_data", out_data[c*W +: W], '0);
    m_reset();
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("md_idle_busy", W'(busy), '0);
    chk("md_idle_done", W'(done), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
